// File: rtl/ddr_cmd_arbiter.sv
// Round-robin write/read command scheduler for a shared DDR controller,
// with triple-buffered frame banks and per-channel beat pointers.
module ddr_cmd_arbiter #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int BURST_LEN       = 256,
    parameter int FRAME_LEN       = 32768,
    parameter int ADDR_STEP       = 8,
    parameter logic [CTRL_ADDR_WIDTH-1:0] BASE_ADDR    = 28'h0000000,
    parameter logic [CTRL_ADDR_WIDTH-1:0] FRAME_OFFSET = 28'h0200000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_req,
    input  logic                       wr_frame_start,
    input  logic                       rd_req,
    input  logic                       rd_frame_start,
    output logic                       wr_cmd_en,
    output logic [CTRL_ADDR_WIDTH-1:0] wr_cmd_addr,
    output logic [31:0]                wr_cmd_len,
    input  logic                       wr_cmd_ready,
    input  logic                       wr_cmd_done,
    output logic                       rd_cmd_en,
    output logic [CTRL_ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [31:0]                rd_cmd_len,
    input  logic                       rd_cmd_ready,
    input  logic                       rd_cmd_done,
    output logic [1:0]                 wr_bank,
    output logic [1:0]                 rd_bank,
    output logic                       busy
);

    localparam int PTR_W = $clog2(FRAME_LEN + 1);
    localparam logic [PTR_W-1:0] P_FRAME = PTR_W'(FRAME_LEN);
    localparam logic [PTR_W-1:0] P_BURST = PTR_W'(BURST_LEN);
    localparam logic [CTRL_ADDR_WIDTH-1:0] A_STEP = CTRL_ADDR_WIDTH'(ADDR_STEP);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_ISSUE = 3'd1,
        S_WR_WAIT  = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4
    } state_t;

    state_t           r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [1:0]       r_wr_bank;
    logic [1:0]       r_rd_bank;
    logic [1:0]       r_last_full;
    logic             r_last_rd;
    logic             r_wr_pend;
    logic             r_rd_pend;

    state_t           w_state_nxt;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [1:0]       w_wr_bank_nxt;
    logic [1:0]       w_rd_bank_nxt;
    logic [1:0]       w_last_full_nxt;
    logic             w_last_rd_nxt;

    logic             w_idle;
    logic             w_wr_apply;
    logic             w_rd_apply;
    logic [1:0]       w_last_full_a;
    logic [1:0]       w_wr_bank_a;
    logic [1:0]       w_rd_bank_a;
    logic [PTR_W-1:0] w_wr_ptr_a;
    logic [PTR_W-1:0] w_rd_ptr_a;
    logic             w_wr_elig;
    logic             w_rd_elig;

    // The bank that is neither being read nor holding the newest full frame.
    function automatic logic [1:0] free_bank(input logic [1:0] rb,
                                             input logic [1:0] lf);
        if (rb == lf)
            free_bank = (rb == 2'd2) ? 2'd0 : rb + 2'd1;
        else
            free_bank = 2'd3 - rb - lf;
    endfunction

    function automatic logic [CTRL_ADDR_WIDTH-1:0] cmd_addr(
        input logic [1:0]       bank,
        input logic [PTR_W-1:0] ptr
    );
        cmd_addr = BASE_ADDR
                 + CTRL_ADDR_WIDTH'(bank) * FRAME_OFFSET
                 + CTRL_ADDR_WIDTH'(ptr) * A_STEP;
    endfunction

    // Frame starts take effect only in IDLE, write before read.
    assign w_idle        = (r_state == S_IDLE);
    assign w_wr_apply    = w_idle & r_wr_pend;
    assign w_rd_apply    = w_idle & r_rd_pend;
    assign w_last_full_a = (w_wr_apply && r_wr_ptr == P_FRAME)
                         ? r_wr_bank : r_last_full;
    assign w_wr_bank_a   = w_wr_apply
                         ? free_bank(r_rd_bank, w_last_full_a) : r_wr_bank;
    assign w_wr_ptr_a    = w_wr_apply ? '0 : r_wr_ptr;
    assign w_rd_bank_a   = w_rd_apply ? w_last_full_a : r_rd_bank;
    assign w_rd_ptr_a    = w_rd_apply ? '0 : r_rd_ptr;
    assign w_wr_elig     = wr_req & (w_wr_ptr_a < P_FRAME);
    assign w_rd_elig     = rd_req & (w_rd_ptr_a < P_FRAME);

    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_wr_bank_nxt   = r_wr_bank;
        w_rd_bank_nxt   = r_rd_bank;
        w_last_full_nxt = r_last_full;
        w_last_rd_nxt   = r_last_rd;
        case (r_state)
            S_IDLE: begin
                w_wr_ptr_nxt    = w_wr_ptr_a;
                w_rd_ptr_nxt    = w_rd_ptr_a;
                w_wr_bank_nxt   = w_wr_bank_a;
                w_rd_bank_nxt   = w_rd_bank_a;
                w_last_full_nxt = w_last_full_a;
                if (w_wr_elig && (!w_rd_elig || r_last_rd)) begin
                    w_state_nxt   = S_WR_ISSUE;
                    w_last_rd_nxt = 1'b0;
                end else if (w_rd_elig) begin
                    w_state_nxt   = S_RD_ISSUE;
                    w_last_rd_nxt = 1'b1;
                end
            end
            S_WR_ISSUE: begin
                if (wr_cmd_ready) begin
                    w_wr_ptr_nxt = r_wr_ptr + P_BURST;
                    w_state_nxt  = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (wr_cmd_done)
                    w_state_nxt = S_IDLE;
            end
            S_RD_ISSUE: begin
                if (rd_cmd_ready) begin
                    w_rd_ptr_nxt = r_rd_ptr + P_BURST;
                    w_state_nxt  = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (rd_cmd_done)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wr_bank   <= 2'd0;
            r_rd_bank   <= 2'd1;
            r_last_full <= 2'd1;
            r_last_rd   <= 1'b1;
            r_wr_pend   <= 1'b0;
            r_rd_pend   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_bank   <= w_wr_bank_nxt;
            r_rd_bank   <= w_rd_bank_nxt;
            r_last_full <= w_last_full_nxt;
            r_last_rd   <= w_last_rd_nxt;
            r_wr_pend   <= wr_frame_start | (r_wr_pend & ~w_wr_apply);
            r_rd_pend   <= rd_frame_start | (r_rd_pend & ~w_rd_apply);
        end
    end

    // Address and length read as zero whenever the command is not valid.
    assign wr_cmd_en   = (r_state == S_WR_ISSUE);
    assign rd_cmd_en   = (r_state == S_RD_ISSUE);
    assign wr_cmd_addr = wr_cmd_en ? cmd_addr(r_wr_bank, r_wr_ptr) : '0;
    assign rd_cmd_addr = rd_cmd_en ? cmd_addr(r_rd_bank, r_rd_ptr) : '0;
    assign wr_cmd_len  = wr_cmd_en ? 32'(BURST_LEN) : 32'd0;
    assign rd_cmd_len  = rd_cmd_en ? 32'(BURST_LEN) : 32'd0;
    assign wr_bank     = r_wr_bank;
    assign rd_bank     = r_rd_bank;
    assign busy        = ~w_idle;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Self-checking bench for ddr_cmd_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_ddr_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_req = 1'b0, wr_frame_start = 1'b0;
    logic        rd_req = 1'b0, rd_frame_start = 1'b0;
    logic        wr_cmd_en, rd_cmd_en;
    logic [27:0] wr_cmd_addr, rd_cmd_addr;
    logic [31:0] wr_cmd_len, rd_cmd_len;
    logic        wr_cmd_ready = 1'b0, wr_cmd_done = 1'b0;
    logic        rd_cmd_ready = 1'b0, rd_cmd_done = 1'b0;
    logic [1:0]  wr_bank, rd_bank;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    ddr_cmd_arbiter dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_frame_start(wr_frame_start),
        .rd_req(rd_req), .rd_frame_start(rd_frame_start),
        .wr_cmd_en(wr_cmd_en), .wr_cmd_addr(wr_cmd_addr),
        .wr_cmd_len(wr_cmd_len), .wr_cmd_ready(wr_cmd_ready),
        .wr_cmd_done(wr_cmd_done),
        .rd_cmd_en(rd_cmd_en), .rd_cmd_addr(rd_cmd_addr),
        .rd_cmd_len(rd_cmd_len), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_done(rd_cmd_done),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {wr_req, rd_req, wr_frame_start, rd_frame_start} = 4'b0;
        {wr_cmd_ready, wr_cmd_done, rd_cmd_ready, rd_cmd_done} = 4'b0;
        tick();
        tick();
        chk("rst_wr_bank", 32'(wr_bank), 32'd0);
        chk("rst_rd_bank", 32'(rd_bank), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en", 32'({wr_cmd_en, rd_cmd_en}), 32'd0);
        chk("rst_addr", 32'(wr_cmd_addr | rd_cmd_addr), 32'd0);
        chk("rst_len", wr_cmd_len | rd_cmd_len, 32'd0);
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_wr_en();
        int n = 0;
        while (wr_cmd_en !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("wr_en_wait", 32'(wr_cmd_en), 32'd1);
    endtask

    // One write command: expected address, then accept, wait, done.
    task automatic issue_wr(input logic [27:0] exp, input int hold);
        wait_wr_en();
        chk("wr_addr", 32'(wr_cmd_addr), 32'(exp));
        chk("wr_len", wr_cmd_len, 32'd256);
        wr_cmd_ready = 1'b1;
        tick();
        wr_cmd_ready = 1'b0;
        chk("wr_en_after_acc", 32'(wr_cmd_en), 32'd0);
        repeat (hold) tick();
        wr_cmd_done = 1'b1;
        tick();
        wr_cmd_done = 1'b0;
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    // Vector table: inputs held for one cycle, outputs seen afterwards.
    typedef struct {
        logic [5:0]  in;     // wr_req rd_req wr_rdy rd_rdy wr_done rd_done
        logic        wen;
        logic [27:0] waddr;
        logic        ren;
        logic [27:0] raddr;
        logic        busy;
    } vec_t;

    vec_t tbl[15];

    // Transaction-level reference: which channel owns the controller,
    // whether its command was taken, and the frame bookkeeping.
    int m_wptr, m_rptr, m_wbank, m_rbank, m_lastfull;
    int m_owner;       // -1 none, 0 write, 1 read
    bit m_taken, m_last_was_wr, m_pw, m_pr;

    function automatic logic [31:0] m_addr(input int bank, input int ptr);
        longint a;
        a = longint'(bank) * 64'h200000 + longint'(ptr) * 8;
        return 32'(a & 64'h0FFFFFFF);
    endfunction

    task automatic m_reset();
        m_wptr = 0; m_rptr = 0; m_wbank = 0; m_rbank = 1; m_lastfull = 1;
        m_owner = -1; m_taken = 0; m_last_was_wr = 0; m_pw = 0; m_pr = 0;
    endtask

    task automatic m_step();
        bit we, re;
        if (m_owner < 0) begin
            if (m_pw) begin
                if (m_wptr == 32768) m_lastfull = m_wbank;
                for (int k = 1; k <= 2; k++) begin
                    if ((m_rbank + k) % 3 != m_lastfull) begin
                        m_wbank = (m_rbank + k) % 3;
                        break;
                    end
                end
                m_wptr = 0;
                m_pw = 0;
            end
            if (m_pr) begin
                m_rbank = m_lastfull;
                m_rptr = 0;
                m_pr = 0;
            end
            we = wr_req && m_wptr < 32768;
            re = rd_req && m_rptr < 32768;
            if (we && (!re || !m_last_was_wr)) begin
                m_owner = 0; m_taken = 0; m_last_was_wr = 1;
            end else if (re) begin
                m_owner = 1; m_taken = 0; m_last_was_wr = 0;
            end
        end else if (!m_taken) begin
            if (m_owner == 0 && wr_cmd_ready) begin
                m_taken = 1; m_wptr += 256;
            end else if (m_owner == 1 && rd_cmd_ready) begin
                m_taken = 1; m_rptr += 256;
            end
        end else if ((m_owner == 0 && wr_cmd_done) ||
                     (m_owner == 1 && rd_cmd_done)) begin
            m_owner = -1;
        end
        if (wr_frame_start) m_pw = 1;
        if (rd_frame_start) m_pr = 1;
    endtask

    task automatic m_compare();
        bit ew, er;
        ew = (m_owner == 0) && !m_taken;
        er = (m_owner == 1) && !m_taken;
        chk("rnd_wr_en", 32'(wr_cmd_en), 32'(ew));
        chk("rnd_rd_en", 32'(rd_cmd_en), 32'(er));
        chk("rnd_wr_addr", 32'(wr_cmd_addr), ew ? m_addr(m_wbank, m_wptr) : 0);
        chk("rnd_rd_addr", 32'(rd_cmd_addr), er ? m_addr(m_rbank, m_rptr) : 0);
        chk("rnd_wr_len", wr_cmd_len, ew ? 32'd256 : 32'd0);
        chk("rnd_rd_len", rd_cmd_len, er ? 32'd256 : 32'd0);
        chk("rnd_banks", 32'({wr_bank, rd_bank}),
            32'(m_wbank * 4 + m_rbank));
        chk("rnd_busy", 32'(busy), 32'(m_owner >= 0));
    endtask

    initial begin
        logic [27:0] held;
        tbl[0]  = '{6'b111100, 1'b1, 28'h0,      1'b0, 28'h0,      1'b1};
        tbl[1]  = '{6'b111100, 1'b0, 28'h0,      1'b0, 28'h0,      1'b1};
        tbl[2]  = '{6'b111110, 1'b0, 28'h0,      1'b0, 28'h0,      1'b0};
        tbl[3]  = '{6'b111100, 1'b0, 28'h0,      1'b1, 28'h200000, 1'b1};
        tbl[4]  = '{6'b111100, 1'b0, 28'h0,      1'b0, 28'h0,      1'b1};
        tbl[5]  = '{6'b111101, 1'b0, 28'h0,      1'b0, 28'h0,      1'b0};
        tbl[6]  = '{6'b111100, 1'b1, 28'h800,    1'b0, 28'h0,      1'b1};
        tbl[7]  = '{6'b111100, 1'b0, 28'h0,      1'b0, 28'h0,      1'b1};
        tbl[8]  = '{6'b111110, 1'b0, 28'h0,      1'b0, 28'h0,      1'b0};
        tbl[9]  = '{6'b111100, 1'b0, 28'h0,      1'b1, 28'h200800, 1'b1};
        tbl[10] = '{6'b111001, 1'b0, 28'h0,      1'b1, 28'h200800, 1'b1};
        tbl[11] = '{6'b111100, 1'b0, 28'h0,      1'b0, 28'h0,      1'b1};
        tbl[12] = '{6'b111101, 1'b0, 28'h0,      1'b0, 28'h0,      1'b0};
        tbl[13] = '{6'b001100, 1'b0, 28'h0,      1'b0, 28'h0,      1'b0};
        tbl[14] = '{6'b011100, 1'b0, 28'h0,      1'b1, 28'h201000, 1'b1};

        tick();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            {wr_req, rd_req, wr_cmd_ready, rd_cmd_ready,
             wr_cmd_done, rd_cmd_done} = tbl[i].in;
            tick();
            chk($sformatf("vec%0d_wen", i), 32'(wr_cmd_en), 32'(tbl[i].wen));
            chk($sformatf("vec%0d_waddr", i), 32'(wr_cmd_addr),
                32'(tbl[i].waddr));
            chk($sformatf("vec%0d_ren", i), 32'(rd_cmd_en), 32'(tbl[i].ren));
            chk($sformatf("vec%0d_raddr", i), 32'(rd_cmd_addr),
                32'(tbl[i].raddr));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
        end

        // Write only, done ten cycles after acceptance.
        do_reset();
        wr_req = 1'b1;
        issue_wr(28'h0, 9);
        issue_wr(28'h800, 9);
        issue_wr(28'h1000, 9);

        // Backpressure holds the command stable; pointer steps once.
        do_reset();
        wr_req = 1'b1;
        wait_wr_en();
        held = wr_cmd_addr;
        chk("bp_first_addr", 32'(held), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_en_stable", 32'(wr_cmd_en), 32'd1);
            chk("bp_addr_stable", 32'(wr_cmd_addr), 32'(held));
        end
        wr_cmd_ready = 1'b1;
        tick();
        wr_cmd_ready = 1'b0;
        chk("bp_en_drop", 32'(wr_cmd_en), 32'd0);
        wr_cmd_done = 1'b1;
        tick();
        wr_cmd_done = 1'b0;
        issue_wr(28'h800, 0);

        // Full frame, then frame starts rotate the banks.
        do_reset();
        wr_req = 1'b1;
        for (int k = 0; k < 128; k++) issue_wr(28'(k * 28'h800), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("full_no_issue", 32'({wr_cmd_en, busy}), 32'd0);
        end
        wr_frame_start = 1'b1;
        tick();
        wr_frame_start = 1'b0;
        tick();
        chk("full_wr_bank", 32'(wr_bank), 32'd2);
        chk("full_new_en", 32'(wr_cmd_en), 32'd1);
        chk("full_new_addr", 32'(wr_cmd_addr), 32'h400000);
        wr_req = 1'b0;
        wr_cmd_ready = 1'b1;
        tick();
        wr_cmd_ready = 1'b0;
        wr_cmd_done = 1'b1;
        tick();
        wr_cmd_done = 1'b0;
        rd_frame_start = 1'b1;
        tick();
        rd_frame_start = 1'b0;
        tick();
        chk("full_rd_bank", 32'(rd_bank), 32'd0);

        // Frame start during WR_WAIT waits for the next IDLE.
        do_reset();
        wr_req = 1'b1;
        wait_wr_en();
        wr_cmd_ready = 1'b1;
        tick();
        wr_cmd_ready = 1'b0;
        wr_frame_start = 1'b1;
        tick();
        wr_frame_start = 1'b0;
        repeat (3) tick();
        chk("mid_bank_held", 32'(wr_bank), 32'd0);
        wr_cmd_done = 1'b1;
        tick();
        wr_cmd_done = 1'b0;
        chk("mid_bank_idle", 32'(wr_bank), 32'd0);
        tick();
        chk("mid_bank_new", 32'(wr_bank), 32'd2);
        chk("mid_en", 32'(wr_cmd_en), 32'd1);
        chk("mid_addr", 32'(wr_cmd_addr), 32'h400000);

        // Asynchronous reset in WR_WAIT; stale done is ignored.
        wr_cmd_ready = 1'b1;
        tick();
        wr_cmd_ready = 1'b0;
        chk("ar_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_banks", 32'({wr_bank, rd_bank}), 32'd1);
        chk("ar_en", 32'({wr_cmd_en, rd_cmd_en}), 32'd0);
        wr_req = 1'b0;
        tick();
        rst = 1'b0;
        wr_cmd_done = 1'b1;
        tick();
        wr_cmd_done = 1'b0;
        tick();
        chk("ar_done_ignored", 32'(busy), 32'd0);
        wr_req = 1'b1;
        issue_wr(28'h0, 1);

        // Randomized run against the reference model.
        do_reset();
        m_reset();
        for (int c = 0; c < 20000; c++) begin
            m_compare();
            wr_req         = ($urandom_range(0, 9) < 7);
            rd_req         = ($urandom_range(0, 9) < 7);
            wr_cmd_ready   = ($urandom_range(0, 1) == 1);
            rd_cmd_ready   = ($urandom_range(0, 1) == 1);
            wr_cmd_done    = ($urandom_range(0, 2) == 0);
            rd_cmd_done    = ($urandom_range(0, 2) == 0);
            wr_frame_start = ($urandom_range(0, 599) == 0);
            rd_frame_start = ($urandom_range(0, 499) == 0);
            m_step();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
